seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/seq_muldiv.sv | 131 +++++++++++++
 rtl/seq_alu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-codes, controller states,
// multiply/divide operation kinds and width helpers.
package alu_pkg;

   localparam int XLEN_DEFAULT = 64;

   localparam logic [4:0] OP_AND  = 5'b0_0000;
   localparam logic [4:0] OP_OR   = 5'b0_0001;
   localparam logic [4:0] OP_ADD  = 5'b0_0010;
   localparam logic [4:0] OP_XOR  = 5'b0_0011;
   localparam logic [4:0] OP_SLL  = 5'b0_0100;
   localparam logic [4:0] OP_SRL  = 5'b0_0101;
   localparam logic [4:0] OP_SUB  = 5'b0_0110;
   localparam logic [4:0] OP_SRA  = 5'b0_0111;
   localparam logic [4:0] OP_SLT  = 5'b0_1000;
   localparam logic [4:0] OP_SLTU = 5'b0_1001;
   localparam logic [4:0] OP_MUL  = 5'b1_0000;
   localparam logic [4:0] OP_MULH = 5'b1_0001;
   localparam logic [4:0] OP_DIV  = 5'b1_0100;
   localparam logic [4:0] OP_DIVU = 5'b1_0101;
   localparam logic [4:0] OP_REM  = 5'b1_0110;
   localparam logic [4:0] OP_REMU = 5'b1_0111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      MD_MUL,
      MD_MULH,
      MD_DIV,
      MD_DIVU,
      MD_REM,
      MD_REMU
   } md_kind_t;

   // Shift-amount width and iteration-counter width both follow from XLEN.
   function automatic int shamt_width(input int xlen);
      return $clog2(xlen);
   endfunction

   function automatic int count_width(input int xlen);
      return $clog2(xlen);
   endfunction

   function automatic logic is_mul_op(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative radix-2 multiplier/divider working on operand magnitudes; takes
// exactly XLEN cycles after start and flags done during the final iteration.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  md_kind_t        kind,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = count_width(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   logic            running;
   logic [CW-1:0]   count;
   md_kind_t        kind_q;
   logic            neg_q;
   logic            div_zero_q;
   logic [XLEN-1:0] dividend_q;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] opnd;

   logic            start_signed;
   logic            start_mul;
   logic            start_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;

   logic            kind_is_mul;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_trial;
   logic [XLEN-1:0] acc_next;
   logic [XLEN-1:0] sh_next;

   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] product_signed;
   logic [XLEN-1:0]   quotient_signed;
   logic [XLEN-1:0]   remainder_signed;

   // Operand conditioning: signed kinds work on magnitudes and remember the
   // sign the final result needs (dividend sign for remainders).
   always_comb begin
      start_signed = (kind == MD_MUL) || (kind == MD_MULH) || (kind == MD_DIV) || (kind == MD_REM);
      start_mul    = (kind == MD_MUL) || (kind == MD_MULH);
      a_mag        = (start_signed && a[XLEN-1]) ? -a : a;
      b_mag        = (start_signed && b[XLEN-1]) ? -b : b;
      start_neg    = 1'b0;
      if (start_signed) begin
         if (kind == MD_REM) begin
            start_neg = a[XLEN-1];
         end else begin
            start_neg = a[XLEN-1] ^ b[XLEN-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         count   <= '0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
      end else if (running) begin
         count <= count + 1'b1;
         if (count == LAST) begin
            running <= 1'b0;
         end
      end
   end

   // acc/sh hold {high, low} product halves for multiply and
   // {partial remainder, shifting dividend/quotient} for divide.
   always_ff @(posedge clk) begin
      if (start) begin
         kind_q     <= kind;
         neg_q      <= start_neg;
         div_zero_q <= (b == '0);
         dividend_q <= a;
         acc        <= '0;
         sh         <= start_mul ? b_mag : a_mag;
         opnd       <= start_mul ? a_mag : b_mag;
      end else if (running) begin
         acc <= acc_next;
         sh  <= sh_next;
      end
   end

   always_comb begin
      kind_is_mul = (kind_q == MD_MUL) || (kind_q == MD_MULH);
      mul_sum     = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
      div_trial   = {acc, sh[XLEN-1]} - {1'b0, opnd};
      if (kind_is_mul) begin
         acc_next = mul_sum[XLEN:1];
         sh_next  = {mul_sum[0], sh[XLEN-1:1]};
      end else if (!div_trial[XLEN]) begin
         acc_next = div_trial[XLEN-1:0];
         sh_next  = {sh[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {acc[XLEN-2:0], sh[XLEN-1]};
         sh_next  = {sh[XLEN-2:0], 1'b0};
      end
   end

   // The result is formed from the last iteration's next values so that it
   // can be captured on the same edge the counter expires.
   always_comb begin
      product          = {acc_next, sh_next};
      product_signed   = neg_q ? -product : product;
      quotient_signed  = neg_q ? -sh_next : sh_next;
      remainder_signed = neg_q ? -acc_next : acc_next;
      case (kind_q)
         MD_MUL:           result = product_signed[XLEN-1:0];
         MD_MULH:          result = product_signed[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:  result = div_zero_q ? '1 : quotient_signed;
         MD_REM, MD_REMU:  result = div_zero_q ? dividend_q : remainder_signed;
         default:          result = '0;
      endcase
   end

   assign done = running && (count == LAST);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative mul/div,
// with valid/ready on both sides and a held result register.
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int SHW  = shamt_width(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd,
   output logic            zero,
   output logic            carry,
   output logic            overflow,
   output logic            busy
);

   state_t          state_q;
   state_t          state_d;
   state_t          accept_target;
   logic            accept;
   logic            mul_op;
   logic            div_op;
   logic            iter_op;

   logic [XLEN:0]   add_ext;
   logic [XLEN:0]   sub_ext;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] sra_val;
   logic            slt_lt;
   logic            sltu_lt;
   logic [XLEN-1:0] alu_rd;
   logic            alu_carry;
   logic            alu_ovf;
   logic            alu_valid;

   md_kind_t        md_kind;
   logic            md_start;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   assign mul_op    = is_mul_op(op);
   assign div_op    = is_div_op(op);
   assign iter_op   = mul_op || div_op;
   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign md_start  = accept && iter_op;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);

   assign add_ext = {1'b0, rs1} + {1'b0, rs2};
   assign sub_ext = {1'b0, rs1} - {1'b0, rs2};
   assign shamt   = rs2[SHW-1:0];
   assign sra_val = $signed(rs1) >>> shamt;
   assign slt_lt  = $signed(rs1) < $signed(rs2);
   assign sltu_lt = rs1 < rs2;

   // Single-cycle datapath; unknown codes leave alu_valid low so even the
   // zero flag stays clear for them.
   always_comb begin
      alu_rd    = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_valid = 1'b1;
      case (op)
         OP_AND:  alu_rd = rs1 & rs2;
         OP_OR:   alu_rd = rs1 | rs2;
         OP_XOR:  alu_rd = rs1 ^ rs2;
         OP_ADD: begin
            alu_rd    = add_ext[XLEN-1:0];
            alu_carry = add_ext[XLEN];
            alu_ovf   = (rs1[XLEN-1] == rs2[XLEN-1]) && (add_ext[XLEN-1] != rs1[XLEN-1]);
         end
         OP_SUB: begin
            alu_rd    = sub_ext[XLEN-1:0];
            alu_carry = sub_ext[XLEN];
            alu_ovf   = (rs1[XLEN-1] != rs2[XLEN-1]) && (sub_ext[XLEN-1] != rs1[XLEN-1]);
         end
         OP_SLL:  alu_rd = rs1 << shamt;
         OP_SRL:  alu_rd = rs1 >> shamt;
         OP_SRA:  alu_rd = sra_val;
         OP_SLT:  alu_rd = {{(XLEN-1){1'b0}}, slt_lt};
         OP_SLTU: alu_rd = {{(XLEN-1){1'b0}}, sltu_lt};
         OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_rd = '0;
         default: alu_valid = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         OP_MULH: md_kind = MD_MULH;
         OP_DIV:  md_kind = MD_DIV;
         OP_DIVU: md_kind = MD_DIVU;
         OP_REM:  md_kind = MD_REM;
         OP_REMU: md_kind = MD_REMU;
         default: md_kind = MD_MUL;
      endcase
   end

   seq_muldiv #(
      .XLEN(XLEN)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .kind   (md_kind),
      .a      (rs1),
      .b      (rs2),
      .done   (md_done),
      .result (md_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Draining DONE and accepting a new op share one cycle, so both IDLE and
   // DONE jump straight to wherever the newly accepted op belongs.
   always_comb begin
      accept_target = mul_op ? ST_MUL : (div_op ? ST_DIV : ST_DONE);
      state_d       = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = accept_target;
            end
         end
         ST_MUL, ST_DIV: begin
            if (md_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = accept ? accept_target : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd       <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept && !iter_op) begin
         rd       <= alu_rd;
         zero     <= alu_valid && (alu_rd == '0);
         carry    <= alu_carry;
         overflow <= alu_ovf;
      end else if (md_done) begin
         rd       <= md_result;
         zero     <= (md_result == '0);
         carry    <= 1'b0;
         overflow <= 1'b0;
      end
   end

endmodule
